// File: rtl/stream_packet_arbiter.sv
// Packet-atomic round-robin arbiter: merges N framed requester streams into one
// registered valid/ready output, holding each grant until the packet's tlast word.
module stream_packet_arbiter #(
    parameter int N  = 4,
    parameter int W  = 38,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic [N*W-1:0]  in_ch,
    input  logic [N-1:0]    in_ch_vld,
    output logic [N-1:0]    in_ch_rdy,
    output logic [W-1:0]    out_ch,
    output logic            out_ch_vld,
    input  logic            out_ch_rdy,
    output logic [SW-1:0]   out_src,
    output logic [15:0]     drop_count
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] lock_idx;

    logic          load_en;
    logic          sel_found;
    logic [SW-1:0] sel;
    logic [W-1:0]  sel_word;
    logic [W-1:0]  lock_word;

    logic          grant;
    logic          fwd;
    logic          stray;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_word;

    assign load_en   = out_ch_rdy | ~out_ch_vld;
    assign sel_word  = in_ch[int'(sel) * W +: W];
    assign lock_word = in_ch[int'(lock_idx) * W +: W];

    // Walk from farthest to nearest so the requester closest after ptr wins.
    always_comb begin : rr_search
        int idx;
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (in_ch_vld[idx]) begin
                sel       = SW'(idx);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin : grant_logic
        grant      = 1'b0;
        fwd        = 1'b0;
        stray      = 1'b0;
        grant_idx  = sel;
        grant_word = sel_word;
        if (state == ST_IDLE) begin
            if (sel_found) begin
                if (!sel_word[0]) begin
                    // Strays are absorbed even under back-pressure; they never reach the output.
                    grant = 1'b1;
                    stray = 1'b1;
                end else if (load_en) begin
                    grant = 1'b1;
                    fwd   = 1'b1;
                end
            end
        end else begin
            grant_idx  = lock_idx;
            grant_word = lock_word;
            if (in_ch_vld[lock_idx] && load_en) begin
                grant = 1'b1;
                fwd   = 1'b1;
            end
        end
    end

    always_comb begin : rdy_decode
        in_ch_rdy = '0;
        if (grant && clear_n)
            in_ch_rdy[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= ST_IDLE;
            ptr      <= SW'(N - 1);
            lock_idx <= '0;
        end else if (grant) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (state == ST_IDLE) begin
                ptr <= grant_idx;
                if (fwd && !grant_word[1]) begin
                    state    <= ST_LOCKED;
                    lock_idx <= grant_idx;
                end
            end else if (grant_word[1]) begin
                state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out_ch     <= '0;
            out_src    <= '0;
            out_ch_vld <= 1'b0;
        end else if (fwd) begin
            out_ch     <= grant_word;
            out_src    <= grant_idx;
            out_ch_vld <= 1'b1;
        end else if (load_en) begin
            out_ch_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            drop_count <= '0;
        else if (stray && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Self-checking bench for stream_packet_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level reference model built on queues.
module tb_stream_packet_arbiter;

    localparam int N  = 4;
    localparam int W  = 38;
    localparam int SW = $clog2(N);

    logic            clk = 1'b0;
    logic            clear_n = 1'b0;
    logic [N*W-1:0]  in_ch = '0;
    logic [N-1:0]    in_ch_vld = '0;
    logic [N-1:0]    in_ch_rdy;
    logic [W-1:0]    out_ch;
    logic            out_ch_vld;
    logic            out_ch_rdy = 1'b1;
    logic [SW-1:0]   out_src;
    logic [15:0]     drop_count;

    always #5 clk = ~clk;

    stream_packet_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .in_ch      (in_ch),
        .in_ch_vld  (in_ch_vld),
        .in_ch_rdy  (in_ch_rdy),
        .out_ch     (out_ch),
        .out_ch_vld (out_ch_vld),
        .out_ch_rdy (out_ch_rdy),
        .out_src    (out_src),
        .drop_count (drop_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Per-requester pending words and enable (valid is shown only when enabled and non-empty).
    logic [W-1:0] q [N][$];
    bit           en [N];

    // Reference model: packet-level view of the arbiter.
    bit           m_locked;
    int           m_lock;
    int           m_ptr;
    bit           m_vld;
    logic [W-1:0] m_out;
    int           m_src;
    int           m_drop;
    logic [N-1:0] e_rdy;
    int           e_acc;
    bit           e_load;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_word(input bit first, input bit last);
        logic [63:0]  r;
        logic [W-1:0] w;
        r    = {$urandom(), $urandom()};
        w    = r[W-1:0];
        w[1] = last;
        w[0] = first;
        return w;
    endfunction

    task automatic push_pkt(input int i, input int len);
        for (int b = 0; b < len; b++)
            q[i].push_back(mk_word(b == 0, b == len - 1));
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_lock   = 0;
        m_ptr    = N - 1;
        m_vld    = 1'b0;
        m_out    = '0;
        m_src    = 0;
        m_drop   = 0;
    endtask

    task automatic model_eval();
        logic [W-1:0] w;
        int idx;
        e_rdy  = '0;
        e_acc  = -1;
        e_load = out_ch_rdy || !m_vld;
        if (!clear_n) return;
        if (m_locked) begin
            if (in_ch_vld[m_lock] && e_load) e_acc = m_lock;
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (in_ch_vld[idx]) begin
                    w = q[idx][0];
                    if (!w[0] || e_load) e_acc = idx;
                    break;
                end
            end
        end
        if (e_acc >= 0) e_rdy[e_acc] = 1'b1;
    endtask

    task automatic model_commit();
        logic [W-1:0] w;
        bit fwd;
        if (e_acc >= 0) begin
            w   = q[e_acc][0];
            fwd = m_locked || w[0];
            if (fwd) begin
                m_out = w;
                m_src = e_acc;
                m_vld = 1'b1;
            end else begin
                if (m_drop < 65535) m_drop++;
                if (e_load) m_vld = 1'b0;
            end
            if (!m_locked) begin
                m_ptr = e_acc;
                if (w[0] && !w[1]) begin
                    m_locked = 1'b1;
                    m_lock   = e_acc;
                end
            end else if (w[1]) begin
                m_locked = 1'b0;
            end
            void'(q[e_acc].pop_front());
        end else if (e_load) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            in_ch_vld[i]      = en[i] && (q[i].size() > 0);
            in_ch[i*W +: W]   = in_ch_vld[i] ? q[i][0] : '0;
        end
        #1;
        model_eval();
        check("rdy", 64'(in_ch_rdy), 64'(e_rdy));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_commit();
        check("out_vld", 64'(out_ch_vld), 64'(m_vld));
        if (m_vld) begin
            check("out_ch", 64'(out_ch), 64'(m_out));
            check("out_src", 64'(out_src), 64'(m_src));
        end
        check("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic step();
        apply_inputs();
        tick();
    endtask

    task automatic reset_check(input string tag);
        clear_n = 1'b0;
        #1;
        check({tag, "_rdy"}, 64'(in_ch_rdy), 64'd0);
        check({tag, "_vld"}, 64'(out_ch_vld), 64'd0);
        check({tag, "_drop"}, 64'(drop_count), 64'd0);
        check({tag, "_out"}, 64'(out_ch), 64'd0);
        check({tag, "_src"}, 64'(out_src), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        int           exp_atom [6];
        logic [W-1:0] bp_w [4];
        int           total;

        exp_atom = '{0, 0, 0, 1, 1, 1};
        model_reset();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1;
            push_pkt(i, 1);
        end

        // Power-on reset with every requester valid.
        @(negedge clk);
        apply_inputs();
        reset_check("por");

        // Round-robin with wrap: single-beat packets from all requesters.
        for (int i = 0; i < N; i++) begin
            push_pkt(i, 1);
            push_pkt(i, 1);
        end
        for (int k = 1; k <= 3 * N; k++) begin
            step();
            check("rr_src", 64'(out_src), 64'((k - 1) % N));
        end
        step();

        // Packet atomicity: two 3-beat packets offered together.
        push_pkt(0, 3);
        push_pkt(1, 3);
        for (int k = 0; k < 6; k++) begin
            step();
            check("atom_vld", 64'(out_ch_vld), 64'd1);
            check("atom_src", 64'(out_src), 64'(exp_atom[k]));
        end
        step();

        // Back-pressure on beat 2 of a 4-beat packet with a competitor waiting.
        push_pkt(2, 4);
        push_pkt(3, 1);
        for (int b = 0; b < 4; b++) bp_w[b] = q[2][b];
        step();
        step();
        check("bp_beat2", 64'(out_ch), 64'(bp_w[1]));
        out_ch_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply_inputs();
            check("bp_rdy", 64'(in_ch_rdy), 64'd0);
            tick();
            check("bp_hold", 64'(out_ch), 64'(bp_w[1]));
        end
        out_ch_rdy = 1'b1;
        step();
        check("bp_beat3", 64'(out_ch), 64'(bp_w[2]));
        step();
        check("bp_beat4", 64'(out_ch), 64'(bp_w[3]));
        step();
        step();

        // Locked owner goes idle while another requester waits.
        push_pkt(1, 3);
        push_pkt(3, 1);
        en[3] = 1'b0;
        step();
        en[1] = 1'b0;
        en[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply_inputs();
            check("lock_rdy3", 64'(in_ch_rdy[3]), 64'd0);
            tick();
        end
        en[1] = 1'b1;
        step();
        apply_inputs();
        check("lock_tlast", 64'(in_ch_rdy), 64'b0010);
        tick();
        apply_inputs();
        check("lock_next", 64'(in_ch_rdy), 64'b1000);
        tick();
        step();

        // Reset mid-packet: remainder is absorbed as strays afterwards.
        push_pkt(2, 4);
        step();
        step();
        push_pkt(0, 1);
        reset_check("mid");
        apply_inputs();
        check("post_rst_grant", 64'(in_ch_rdy), 64'b0001);
        tick();
        step();
        check("stray_1", 64'(drop_count), 64'd1);
        step();
        check("stray_2", 64'(drop_count), 64'd2);
        q[2].push_back(mk_word(1'b0, 1'b0));
        step();
        check("stray_3", 64'(drop_count), 64'd3);
        check("stray_vld", 64'(out_ch_vld), 64'd0);

        // Drive the drop counter to its ceiling.
        for (int k = 0; k < 65531; k++) begin
            q[2].push_back(mk_word(1'b0, $urandom_range(1)));
            step();
        end
        check("sat_fffe", 64'(drop_count), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            q[2].push_back(mk_word(1'b0, 1'b0));
            step();
        end
        check("sat_ffff", 64'(drop_count), 64'hFFFF);
        reset_check("sat_rst");

        // Random traffic: packets, strays, valid gaps and output back-pressure.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0) begin
                    if ($urandom_range(9) == 0)
                        q[i].push_back(mk_word(1'b0, $urandom_range(1)));
                    else
                        push_pkt(i, $urandom_range(1, 4));
                end
                en[i] = ($urandom_range(3) != 0);
            end
            out_ch_rdy = ($urandom_range(9) < 7);
            step();
        end

        for (int i = 0; i < N; i++) en[i] = 1'b1;
        out_ch_rdy = 1'b1;
        for (int k = 0; k < 200; k++) begin
            total = 0;
            for (int i = 0; i < N; i++) total += q[i].size();
            if (total == 0) break;
            step();
        end
        total = 0;
        for (int i = 0; i < N; i++) total += q[i].size();
        check("drain_empty", 64'(total), 64'd0);
        step();
        check("drain_vld", 64'(out_ch_vld), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_packet_arbiter.md
# stream_packet_arbiter

Packet-atomic round-robin arbiter that merges N framed requester streams into one stream feeding the stream cleaner. A packet is the run of words from a `tfirst` word through the next `tlast` word. Once a packet's first word is granted, the arbiter holds the grant until that packet's `tlast` word, so packets are never interleaved. Stray words that arrive outside a packet are absorbed and counted, and the output stage is a single register with the same valid/ready discipline as the cleaner.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `W`, default 38: word width. Field layout is `[W-1:6]` data, `[5:2]` side field, `[1]` tlast, `[0]` tfirst.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `clear_n`  in  1  reset, asynchronous and active-low.
- `in_ch`  in  N*W  requester words; requester i occupies `[i*W +: W]`.
- `in_ch_vld`  in  N  per-requester valid.
- `in_ch_rdy`  out  N  per-requester accept strobe. It is combinational and depends on `in_ch_vld`. A word transfers when its rdy bit is 1.
- `out_ch`  out  W  registered output word.
- `out_ch_vld`  out  1  registered output valid.
- `out_ch_rdy`  in  1  downstream ready.
- `out_src`  out  clog2(N)  index of the requester that supplied `out_ch`; registered with `out_ch`.
- `drop_count`  out  16  saturating count of absorbed stray words.

## Operation
- **Output stage**
  - `load_en = out_ch_rdy | ~out_ch_vld`.
  - A forwarded word loads `out_ch`/`out_src` and sets `out_ch_vld`.
  - If `load_en` is 1 and nothing is forwarded, `out_ch_vld` clears. Otherwise the output stage holds.
- **State and pointer**
  - States are IDLE and LOCKED. There is also a `lock_idx` register.
  - `ptr` is the last-granted index.
- **IDLE**
  - `sel` is the first i in order ptr+1, ptr+2, … (mod N) with `in_ch_vld[i]=1`.
  - If no requester is valid, all rdy bits are 0.
  - Selected word with tfirst=0 (stray): accept it regardless of `load_en`. Do not forward it. Increment `drop_count`, saturating at 0xFFFF. Set `ptr=sel`.
  - Selected word with tfirst=1: accept only if `load_en`, then forward it and set `ptr=sel`.
    - tlast=1 (single-beat packet): stay in IDLE.
    - tlast=0: go to LOCKED with `lock_idx=sel`.
- **LOCKED**
  - Only `lock_idx` may be granted; all other rdy bits are 0.
  - The word is accepted when `in_ch_vld[lock_idx] & load_en`, and is forwarded unchanged, whatever its tfirst value.
  - Accepted tlast=1: go to IDLE.
  - An idle locked requester produces bubbles. There is no timeout.
- **Data handling**
  - At most one rdy bit is 1 per cycle.
  - Words are never modified.
  - A word is never both forwarded and dropped.

## Timing
- **Reset values** while `clear_n=0`, applied asynchronously:
  - `out_ch=0`, `out_ch_vld=0`, `out_src=0`, `drop_count=0`.
  - State IDLE, `ptr=N-1` (requester 0 has first priority), `lock_idx=0`.
  - `in_ch_rdy=0`.
- **Reset mid-packet:** the packet is abandoned. After release, arbitration restarts in IDLE, so the rest of the old packet is absorbed as strays.
- **Latency:** 1 cycle from acceptance to `out_ch_vld=1`.
- **Throughput:** 1 word/cycle while `out_ch_rdy=1`. A packet end followed by a new grant has no bubble: a tlast accept in cycle t allows a new tfirst accept in cycle t+1.
- **Back-pressure:** with `out_ch_vld=1` and `out_ch_rdy=0`, `out_ch`/`out_src` hold and no tfirst word is accepted. Stray absorption continues in IDLE.
- **Same-cycle output:** pop of the current output and load of the next word happen in the same edge.
- **Pointer wrap:** N-1 → 0.

## Test plan
- **Reset:** assert `clear_n=0` mid-stream -> `out_ch_vld=0`, `drop_count=0`, `in_ch_rdy=0` immediately. After release, the first grant goes to requester 0.
- **Packet atomicity:** requesters 0 and 1 each present a 3-beat packet in the same cycle, with `out_ch_rdy=1` -> output shows 0,0,0 then 1,1,1 on `out_src` in 6 consecutive cycles, with no interleaving.
- **Round-robin and wrap:** all 4 requesters stream single-beat packets (tfirst=tlast=1) continuously -> `out_src` sequence is 0,1,2,3,0,1….
- **Stray handling:** requester 2 presents tfirst=0 words in IDLE -> each is accepted, none is forwarded, and `drop_count` counts 1,2,3. Preloading 0xFFFE, then 3 strays -> `drop_count` holds at 0xFFFF.
- **Back-pressure:** `out_ch_rdy=0` for 5 cycles on beat 2 of a 4-beat packet -> `out_ch` is stable, all rdy bits are 0, and no beat is lost or duplicated. Beats 3 and 4 follow on consecutive cycles once ready returns.
- **Lock with idle owner:** requester 1 is locked and its valid drops for 3 cycles while requester 3 is valid -> requester 3's rdy stays 0. Requester 3 is granted only in the cycle after requester 1's tlast is accepted.
